// File: rtl/permutation_inverse.sv
// Iterative inverse of the Ascon permutation p^r on a 320-bit state.
// One inverse round per clock; start/done handshake like the forward block.
module permutation_inverse #(
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [319:0] S,
    input  logic [4:0]   rounds,
    output logic [319:0] out,
    output logic [4:0]   ctr,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Cyclic rotations of a 64-bit word.
    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} << n;
        return d[127:64];
    endfunction

    // Product of two polynomials in GF(2)[x]/(x^64+1), bit i = coeff of x^i.
    function automatic logic [63:0] pmul(input logic [63:0] p, input logic [63:0] q);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (p[i]) begin
                r = r ^ rotl64(q, i);
            end
        end
        return r;
    endfunction

    // Rotation set of L^-1 for L = 1 + x^a + x^b.
    // Squaring is linear in GF(2), so L^64 = 1 + 1 + 1 = 1 and
    // L^-1 = L^63 = prod_{i=0..5} (1 + x^(a*2^i) + x^(b*2^i)).
    function automatic logic [63:0] linv_mask(input int a, input int b);
        logic [63:0] acc;
        logic [63:0] f;
        acc = 64'd1;
        for (int i = 0; i < 6; i++) begin
            f = 64'd1;
            f = f ^ (64'd1 << ((a << i) % 64));
            f = f ^ (64'd1 << ((b << i) % 64));
            acc = pmul(acc, f);
        end
        return acc;
    endfunction

    // Fixed rotation sets of the five inverse linear layers.
    localparam logic [63:0] LINV0 = linv_mask(19, 28);
    localparam logic [63:0] LINV1 = linv_mask(61, 39);
    localparam logic [63:0] LINV2 = linv_mask(1, 6);
    localparam logic [63:0] LINV3 = linv_mask(10, 17);
    localparam logic [63:0] LINV4 = linv_mask(7, 41);

    // XOR of the rotations selected by a rotation set.
    function automatic logic [63:0] lin_apply(input logic [63:0] x, input logic [63:0] mask);
        logic [63:0] r;
        r = '0;
        for (int m = 0; m < 64; m++) begin
            if (mask[m]) begin
                r = r ^ rotr64(x, m);
            end
        end
        return r;
    endfunction

    function automatic logic [4:0] inv_sbox(input logic [4:0] v);
        logic [4:0] r;
        case (v)
            5'd0:    r = 5'd20;
            5'd1:    r = 5'd26;
            5'd2:    r = 5'd7;
            5'd3:    r = 5'd13;
            5'd4:    r = 5'd0;
            5'd5:    r = 5'd9;
            5'd6:    r = 5'd14;
            5'd7:    r = 5'd18;
            5'd8:    r = 5'd10;
            5'd9:    r = 5'd6;
            5'd10:   r = 5'd29;
            5'd11:   r = 5'd1;
            5'd12:   r = 5'd25;
            5'd13:   r = 5'd21;
            5'd14:   r = 5'd19;
            5'd15:   r = 5'd30;
            5'd16:   r = 5'd24;
            5'd17:   r = 5'd22;
            5'd18:   r = 5'd11;
            5'd19:   r = 5'd17;
            5'd20:   r = 5'd3;
            5'd21:   r = 5'd5;
            5'd22:   r = 5'd28;
            5'd23:   r = 5'd31;
            5'd24:   r = 5'd23;
            5'd25:   r = 5'd27;
            5'd26:   r = 5'd4;
            5'd27:   r = 5'd8;
            5'd28:   r = 5'd15;
            5'd29:   r = 5'd12;
            5'd30:   r = 5'd16;
            5'd31:   r = 5'd2;
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    // One inverse round for round index k: inverse linear, inverse S-box,
    // then constant removal.
    function automatic logic [319:0] inv_round(input logic [319:0] s, input logic [3:0] k);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] y0, y1, y2, y3, y4;
        logic [4:0]  v;
        x0 = lin_apply(s[319:256], LINV0);
        x1 = lin_apply(s[255:192], LINV1);
        x2 = lin_apply(s[191:128], LINV2);
        x3 = lin_apply(s[127:64],  LINV3);
        x4 = lin_apply(s[63:0],    LINV4);
        y0 = '0;
        y1 = '0;
        y2 = '0;
        y3 = '0;
        y4 = '0;
        for (int j = 0; j < 64; j++) begin
            v = inv_sbox({x0[j], x1[j], x2[j], x3[j], x4[j]});
            y0[j] = v[4];
            y1[j] = v[3];
            y2[j] = v[2];
            y3[j] = v[1];
            y4[j] = v[0];
        end
        y2 = y2 ^ {56'd0, 4'd15 - k, k};
        return {y0, y1, y2, y3, y4};
    endfunction

    state_t         state, state_n;
    logic [319:0]   st, st_n;
    logic [319:0]   out_q, out_n;
    logic [4:0]     ctr_q, ctr_n;
    logic [4:0]     r_eff, r_eff_n;
    logic [4:0]     r_clamp;
    logic [3:0]     rk;
    logic [319:0]   round_out;

    assign r_clamp = (rounds > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : rounds;
    assign out     = out_q;
    assign ctr     = ctr_q;

    // Round index: the last forward round is undone first.
    always_comb begin
        rk        = 4'(MAX_ROUNDS - int'(r_eff) + int'(ctr_q) - 1);
        round_out = inv_round(st, rk);
    end

    // State, datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            st    <= '0;
            out_q <= '0;
            ctr_q <= '0;
            r_eff <= '0;
        end else begin
            state <= state_n;
            st    <= st_n;
            out_q <= out_n;
            ctr_q <= ctr_n;
            r_eff <= r_eff_n;
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_n = state;
        st_n    = st;
        out_n   = out_q;
        ctr_n   = ctr_q;
        r_eff_n = r_eff;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    st_n    = S;
                    r_eff_n = r_clamp;
                    ctr_n   = r_clamp;
                    if (r_clamp == 5'd0) begin
                        out_n   = S;
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                st_n  = round_out;
                ctr_n = ctr_q - 5'd1;
                if (ctr_q == 5'd1) begin
                    out_n   = round_out;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_permutation_inverse.sv
// Self-checking bench for permutation_inverse: round trips through a
// behavioural forward Ascon permutation model.
module tb_permutation_inverse;

    logic         clk;
    logic         rst;
    logic         start;
    logic [319:0] S;
    logic [4:0]   rounds;
    logic [319:0] out;
    logic [4:0]   ctr;
    logic         busy;
    logic         done;

    int checks;
    int failures;

    int inv_tab [32] = '{20, 26, 7, 13, 0, 9, 14, 18, 10, 6, 29, 1, 25, 21, 19, 30,
                         24, 22, 11, 17, 3, 5, 28, 31, 23, 27, 4, 8, 15, 12, 16, 2};
    int fwd [32];
    int rot_a [5] = '{19, 61, 1, 10, 7};
    int rot_b [5] = '{28, 39, 6, 17, 41};

    permutation_inverse #(.MAX_ROUNDS(12)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .S      (S),
        .rounds (rounds),
        .out    (out),
        .ctr    (ctr),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Forward Ascon p^r: constant addition, S-box, linear diffusion.
    function automatic logic [319:0] perm_fwd(input logic [319:0] s, input int r);
        logic [63:0] x [5];
        logic [4:0]  v;
        logic [4:0]  w;
        int          re;
        re = (r > 12) ? 12 : r;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int k = 12 - re; k < 12; k++) begin
            x[2] = x[2] ^ 64'(((15 - k) << 4) | k);
            for (int j = 0; j < 64; j++) begin
                v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                w = 5'(fwd[v]);
                for (int i = 0; i < 5; i++) x[i][j] = w[4 - i];
            end
            for (int i = 0; i < 5; i++)
                x[i] = x[i] ^ ror(x[i], rot_a[i]) ^ ror(x[i], rot_b[i]);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rnd320();
        logic [319:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r = {r[287:0], 32'($urandom())};
        return r;
    endfunction

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 50 && (busy || done); i++) @(negedge clk);
    endtask

    // Issue one operation, scramble inputs while it runs, trace ctr/busy.
    task automatic run_op(input logic [319:0] s_in, input logic [4:0] r,
                          output logic [319:0] res, output int lat);
        int re;
        re = (r > 5'd12) ? 12 : int'(r);
        wait_idle();
        S      = s_in;
        rounds = r;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        for (int n = 1; n <= 40; n++) begin
            lat = n;
            if (n <= re + 1) begin
                chk("ctr", 320'(ctr), 320'(re + 1 - n));
                chk("busy", 320'(busy), 320'(n <= re));
            end
            if (done) break;
            S      = rnd320();
            rounds = 5'($urandom_range(0, 31));
            @(posedge clk);
            #1;
        end
        res = out;
    endtask

    logic [319:0] s0, c, x, res;
    logic [319:0] orig [3];
    logic [319:0] cin  [3];
    int           lat;
    int           nd, cyc, last, dn;
    int           rlist [3] = '{1, 6, 8};

    initial begin
        checks   = 0;
        failures = 0;
        for (int v = 0; v < 32; v++) fwd[inv_tab[v]] = v;
        rst    = 1'b1;
        start  = 1'b0;
        S      = '0;
        rounds = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", out, '0);
        chk("rst_ctr", 320'(ctr), 320'd0);
        chk("rst_busy", 320'(busy), 320'd0);
        chk("rst_done", 320'(done), 320'd0);
        rst = 1'b0;

        s0 = 320'hb1052995b8707739d6d42cbb78bb010af1c1629ec1ff700bda64243d428eb536db31c36d00000000;
        c = perm_fwd(s0, 12);
        run_op(c, 5'd12, res, lat);
        chk("rt12_out", res, s0);
        chk("rt12_lat", 320'(lat), 320'd13);

        foreach (rlist[ri]) begin
            for (int t = 0; t < 200; t++) begin
                x = rnd320();
                c = perm_fwd(x, rlist[ri]);
                run_op(c, 5'(rlist[ri]), res, lat);
                chk("rt_rand_out", res, x);
                chk("rt_rand_lat", 320'(lat), 320'(rlist[ri] + 1));
            end
        end

        s0 = 320'h0123456789abcdeffedcba98765432100011223344556677_8899aabbccddeeff0f1e2d3c4b5a6978;
        run_op(s0, 5'd0, res, lat);
        chk("r0_out", res, s0);
        chk("r0_lat", 320'(lat), 320'd1);

        x = rnd320();
        c = perm_fwd(x, 12);
        run_op(c, 5'd20, res, lat);
        chk("r20_out", res, x);
        chk("r20_lat", 320'(lat), 320'd13);

        x = rnd320();
        c = perm_fwd(x, 12);
        wait_idle();
        S      = c;
        rounds = 5'd12;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 0; n < 20 && ctr != 5'd5; n++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_ctr", 320'(ctr), 320'd5);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_out", out, '0);
        chk("mid_rst_busy", 320'(busy), 320'd0);
        chk("mid_rst_done", 320'(done), 320'd0);
        dn = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        chk("mid_no_done", 320'(dn), 320'd0);
        run_op(c, 5'd12, res, lat);
        chk("after_rst_out", res, x);

        for (int i = 0; i < 3; i++) begin
            orig[i] = rnd320();
            cin[i]  = perm_fwd(orig[i], 6);
        end
        wait_idle();
        S      = cin[0];
        rounds = 5'd6;
        start  = 1'b1;
        nd     = 0;
        cyc    = 0;
        last   = 0;
        for (int n = 0; n < 60 && nd < 3; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                chk("b2b_out", out, orig[nd]);
                if (nd > 0) chk("b2b_period", 320'(cyc - last), 320'd8);
                last = cyc;
                nd++;
                if (nd < 3) S = cin[nd];
                else start = 1'b0;
            end else if (busy) begin
                S = rnd320();
            end
        end
        start = 1'b0;
        chk("b2b_count", 320'(nd), 320'd3);

        c = perm_fwd('0, 1);
        run_op(c, 5'd1, res, lat);
        chk("zero_r1", res, 320'h0);
        chk("zero_r1_lat", 320'(lat), 320'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
